// File: rtl/adc_avg_compare.sv
`default_nettype none
// ============================================================================
// Module   : adc_avg_compare
// Brief    : Averages windows of ADC samples and flags new maxima against LV.
// Revision : 1.0 - initial release
// ============================================================================
module adc_avg_compare #(
  parameter int DATA_W   = 12,
  parameter int AVG_LOG2 = 2,
  parameter int HYST     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample,
  input  logic [DATA_W-1:0] lv,
  input  logic              clear,
  output logic [DATA_W-1:0] pv,
  output logic              avg_valid,
  output logic              gt,
  output logic              busy
);

  localparam int                  c_ACC_W    = DATA_W + AVG_LOG2;
  localparam logic [AVG_LOG2-1:0] c_CNT_LAST = '1;
  localparam logic [DATA_W:0]     c_HYST     = (DATA_W + 1)'(HYST);

  logic [c_ACC_W-1:0]  r_acc;
  logic [AVG_LOG2-1:0] r_cnt;
  logic                r_first;
  logic [DATA_W-1:0]   r_pv;
  logic                r_avg_valid;
  logic                r_gt;

  logic [c_ACC_W-1:0]  w_sum;
  logic [DATA_W-1:0]   w_avg;
  logic                w_last;
  logic                w_gt;

  // Accumulator is sized so a full window of max-scale samples never overflows.
  assign w_sum  = r_acc + c_ACC_W'(sample);
  assign w_avg  = w_sum[c_ACC_W-1:AVG_LOG2];
  assign w_last = sample_valid && (r_cnt == c_CNT_LAST);
  // One extra bit keeps LV + HYST from wrapping near full scale.
  assign w_gt   = r_first || ({1'b0, w_avg} > ({1'b0, lv} + c_HYST));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_first     <= 1'b1;
      r_pv        <= '0;
      r_avg_valid <= 1'b0;
      r_gt        <= 1'b0;
    end else begin
      r_avg_valid <= 1'b0;
      r_gt        <= 1'b0;
      if (clear) begin
        r_acc   <= '0;
        r_cnt   <= '0;
        r_first <= 1'b1;
      end else if (sample_valid) begin
        if (w_last) begin
          r_pv        <= w_avg;
          r_avg_valid <= 1'b1;
          r_gt        <= w_gt;
          r_acc       <= '0;
          r_cnt       <= '0;
          r_first     <= 1'b0;
        end else begin
          r_acc <= w_sum;
          r_cnt <= r_cnt + AVG_LOG2'(1);
        end
      end
    end
  end

  assign pv        = r_pv;
  assign avg_valid = r_avg_valid;
  assign gt        = r_gt;
  assign busy      = (r_cnt != '0);

endmodule
`default_nettype wire

// File: tb/tb_adc_avg_compare.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_avg_compare
// Brief    : Directed scoreboard bench for adc_avg_compare (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_avg_compare;

  logic        clk;
  logic        rst_n;
  logic        sample_valid;
  logic [11:0] sample;
  logic [11:0] lv;
  logic        clear;
  logic [11:0] pv;
  logic        avg_valid;
  logic        gt;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state and expected {avg, gt} results awaiting the DUT strobe.
  logic [13:0] m_acc;
  int          m_cnt;
  logic        m_first;
  logic [12:0] sb_q[$];

  adc_avg_compare #(.DATA_W(12), .AVG_LOG2(2), .HYST(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_valid (sample_valid),
    .sample       (sample),
    .lv           (lv),
    .clear        (clear),
    .pv           (pv),
    .avg_valid    (avg_valid),
    .gt           (gt),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_acc   = '0;
    m_cnt   = 0;
    m_first = 1'b1;
    sb_q.delete();
  endtask

  // One clock cycle: drive inputs, update the model, then check the outputs.
  task automatic step(input logic v, input logic [11:0] d, input logic c);
    logic        exp_v;
    logic [13:0] sum;
    logic [11:0] avg;
    logic        g;
    logic [12:0] ent;
    sample_valid = v;
    sample       = d;
    clear        = c;
    exp_v        = 1'b0;
    if (c) begin
      m_acc   = '0;
      m_cnt   = 0;
      m_first = 1'b1;
    end else if (v) begin
      sum = m_acc + {2'b00, d};
      if (m_cnt == 3) begin
        avg = sum[13:2];
        g   = m_first || ({1'b0, avg} > ({1'b0, lv} + 13'd2));
        sb_q.push_back({avg, g});
        m_acc   = '0;
        m_cnt   = 0;
        m_first = 1'b0;
        exp_v   = 1'b1;
      end else begin
        m_acc = sum;
        m_cnt = m_cnt + 1;
      end
    end
    @(posedge clk);
    #1;
    chk("avg_valid", avg_valid, exp_v);
    if (avg_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_strobe", 1, 0);
      end else begin
        ent = sb_q.pop_front();
        chk("pv", pv, ent[12:1]);
        chk("gt", gt, ent[0]);
      end
    end else begin
      chk("gt_idle", gt, 0);
    end
    chk("busy", busy, (m_cnt != 0));
    sample_valid = 1'b0;
    clear        = 1'b0;
  endtask

  task automatic window(input logic [11:0] d);
    for (int i = 0; i < 4; i++) step(1'b1, d, 1'b0);
  endtask

  initial begin
    rst_n        = 1'b0;
    sample_valid = 1'b0;
    sample       = '0;
    lv           = '0;
    clear        = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pv", pv, 0);
    chk("reset_avg_valid", avg_valid, 0);
    chk("reset_gt", gt, 0);
    chk("reset_busy", busy, 0);
    rst_n = 1'b1;

    // Scenario 1: first window of a sweep always wins.
    step(1'b1, 12'd100, 1'b0);
    step(1'b1, 12'd104, 1'b0);
    chk("s1_busy_mid", busy, 1);
    step(1'b1, 12'd108, 1'b0);
    step(1'b1, 12'd112, 1'b0);
    chk("s1_pv", pv, 106);
    chk("s1_gt", gt, 1);
    step(1'b0, 12'd0, 1'b0);
    chk("s1_strobes_low", {avg_valid, gt}, 0);
    chk("s1_pv_hold", pv, 106);

    // Scenario 2: hysteresis margin.
    lv = 12'd106;
    window(12'd108);
    chk("s2_pv108", pv, 108);
    chk("s2_gt0", gt, 0);
    lv = 12'd106;
    window(12'd109);
    chk("s2_pv109", pv, 109);
    chk("s2_gt1", gt, 1);

    // Scenario 3: gaps in sample_valid, truncating average.
    lv = 12'd109;
    step(1'b1, 12'd10, 1'b0);
    step(1'b1, 12'd10, 1'b0);
    repeat (3) step(1'b0, 12'd0, 1'b0);
    step(1'b1, 12'd10, 1'b0);
    step(1'b0, 12'd0, 1'b0);
    chk("s3_no_early_strobe", avg_valid, 0);
    step(1'b1, 12'd11, 1'b0);
    chk("s3_pv", pv, 10);
    chk("s3_strobe", avg_valid, 1);
    step(1'b0, 12'd0, 1'b0);
    chk("s3_strobe_once", avg_valid, 0);

    // Scenario 4: full-scale boundary.
    lv = 12'd4094;
    window(12'd4095);
    chk("s4_pv", pv, 4095);
    chk("s4_gt0", gt, 0);
    lv = 12'd4000;
    window(12'd4095);
    chk("s4_gt1", gt, 1);

    // Scenario 5: clear mid-window discards samples and rearms FIRST.
    step(1'b1, 12'd50, 1'b0);
    step(1'b1, 12'd50, 1'b0);
    step(1'b1, 12'd50, 1'b1);
    chk("s5_clear_no_strobe", {avg_valid, gt}, 0);
    chk("s5_clear_busy", busy, 0);
    lv = 12'd3000;
    window(12'd5);
    chk("s5_pv", pv, 5);
    chk("s5_gt_first", gt, 1);
    lv = 12'd5;
    window(12'd5);
    chk("s5_gt0", gt, 0);

    // Scenario 6: continuous samples, then asynchronous reset mid-window.
    lv = 12'd5;
    window(12'd200);
    chk("s6_w1_gt", gt, 1);
    lv = 12'd200;
    window(12'd200);
    chk("s6_w2_gt", gt, 0);
    step(1'b1, 12'd200, 1'b0);
    step(1'b1, 12'd200, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("s6_rst_pv", pv, 0);
    chk("s6_rst_busy", busy, 0);
    chk("s6_rst_strobes", {avg_valid, gt}, 0);
    model_reset();
    step(1'b0, 12'd0, 1'b0);
    rst_n = 1'b1;
    window(12'd200);
    chk("s6_after_rst_pv", pv, 200);
    chk("s6_after_rst_gt", gt, 1);
    step(1'b0, 12'd0, 1'b0);

    chk("scoreboard_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/adc_avg_compare.md
# adc_avg_compare

- Front-end stage that turns raw ADC conversions into a decision for the max-voltage register.
- Averages a fixed-size window of ADC samples, then compares the average against the register's current stored maximum (LV).
- Drives the register's enable (GT) and data (PV) inputs.
- Its averaging suppresses single-sample noise spikes that would otherwise be latched as a false maximum during a tracking sweep.

## Interface

- DATA_W, 12, ADC sample width and width of PV/LV.
- AVG_LOG2, 2, log2 of samples per averaging window (window = 2^AVG_LOG2).
- HYST, 2, margin in LSBs the average must exceed LV by to count as a new maximum.

- CLK  in  1  system clock, all state on rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- SAMPLE_VALID  in  1  SAMPLE carries a new conversion this cycle.
- SAMPLE  in  DATA_W  raw ADC value, unsigned.
- LV  in  DATA_W  currently stored maximum from the max register.
- CLEAR  in  1  synchronous pulse: abort current window, start a new sweep.
- PV  out  DATA_W  registered window average.
- AVG_VALID  out  1  one-cycle strobe, PV updated this cycle.
- GT  out  1  one-cycle strobe coincident with AVG_VALID, PV is a new maximum.
- BUSY  out  1  window partially filled (count ≠ 0).

## Operation

- State:
  - accumulator ACC, width DATA_W+AVG_LOG2, unsigned, cannot overflow;
  - sample counter CNT, AVG_LOG2 bits;
  - FIRST flag.
- Each accepted sample (SAMPLE_VALID=1) adds to ACC and increments CNT.
- Gaps in SAMPLE_VALID are allowed; state holds.
- Window completes on the sample that brings CNT to 2^AVG_LOG2. On that edge:
  - PV <= (ACC + SAMPLE) >> AVG_LOG2 (truncating, no rounding);
  - AVG_VALID <= 1;
  - ACC and CNT return to 0.
- GT <= 1 on the same edge if FIRST=1, or if avg > LV + HYST.
  - Compare is done in DATA_W+1 bits, so LV + HYST never wraps.
  - If LV + HYST ≥ 2^DATA_W, GT stays 0 unless FIRST=1.
- FIRST is set by reset and by CLEAR. It is cleared when the next window completes: the first average of a sweep always wins regardless of stale LV.
- LV is sampled on the completing edge only.
- AVG_VALID and GT are 0 in every cycle not described above.
- PV holds its value between windows.
- CLEAR:
  - ACC <= 0, CNT <= 0, FIRST <= 1; no AVG_VALID/GT that cycle.
  - CLEAR together with SAMPLE_VALID: the sample is discarded and the new window starts empty.
  - CLEAR wins over a completing sample.
- Reset (any time, including mid-window): PV=0, AVG_VALID=0, GT=0, BUSY=0, ACC=0, CNT=0, FIRST=1.

## Timing

- Latency: AVG_VALID/GT/PV are visible one cycle after the edge that accepts the last sample of a window.
- Throughput: one sample per cycle. A sample in the cycle after completion is the first of the next window, with no stall or bubble.
- Continuous SAMPLE_VALID: AVG_VALID fires every 2^AVG_LOG2 cycles.
- BUSY is registered and reflects CNT after each edge.
- GT is a single-cycle strobe. The max register captures PV on that cycle, and the updated LV is available to the next window's compare.

## Test plan

All scenarios use the defaults (DATA_W=12, AVG_LOG2=2, HYST=2).

1. Reset, then samples 100, 104, 108, 112 on consecutive cycles -> one cycle later: PV=106, AVG_VALID=1, GT=1 (FIRST); both strobes low the following cycle; BUSY=0.
2. LV=106, four samples of 108 -> PV=108, AVG_VALID=1, GT=0 (not > 108). Then four samples of 109 -> PV=109, GT=1.
3. Samples 10, 10, 10, 11 with idle gaps of 0, 3 and 1 cycles between them -> PV=10 (41>>2 truncated), AVG_VALID exactly once, one cycle after the fourth sample.
4. Boundary: LV=4094, four samples of 4095 after a completed first window -> PV=4095, GT=0, no overflow. LV=4000, same samples -> GT=1.
5. Two samples of 50, then CLEAR together with a third sample of 50, then LV=3000 and four samples of 5 -> no strobe at CLEAR; PV=5, GT=1 (FIRST after CLEAR). Next window of 5s -> GT=0.
6. SAMPLE_VALID held high for 8 cycles with value 200 -> AVG_VALID on cycles 5 and 9 only. Then RST_N asserted low after 2 samples of a third window -> PV=0, BUSY=0, strobes 0 immediately. After release, 4 samples -> GT=1.
